// File: rtl/spi_byte_feeder_pkg.sv
// Shared types and constants for the SSD1306 SPI byte feeder.
// Holds the feeder FSM state encoding and the D/C flag values.
package spi_byte_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Small synchronous FIFO of {dc, data} entries.
// Pointers carry one extra wrap bit so full and empty fall out of a compare.
module spi_byte_fifo
  import spi_byte_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   push,
  input  entry_t wr_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_feeder.sv
// Feeds queued command/data bytes to an 8-bit SPI shift register for an SSD1306,
// driving D/C and chip select and keeping CS asserted across same-D/C bursts.
module spi_byte_feeder
  import spi_byte_feeder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CS_HOLD = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_dc,
  output logic       full,
  input  logic       sr_ready,
  output logic       sr_start,
  output logic [7:0] sr_data,
  output logic       dc_out,
  output logic       cs_n_out,
  output logic       busy
);

  localparam int HW = $clog2(CS_HOLD + 1);

  state_t        state;
  state_t        state_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  entry_t        head;
  logic          fifo_empty;
  logic          pop;
  logic          load;

  spi_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (wr_en),
    .wr_entry ('{dc: wr_dc, data: wr_data}),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    pop        = 1'b0;
    sr_start   = 1'b0;
    case (state)
      IDLE:      if (!fifo_empty) state_next = SETUP;
      SETUP:     state_next = START;
      START: begin
        if (sr_ready) begin
          sr_start   = 1'b1;
          pop        = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (!sr_ready) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (sr_ready) begin
          if (!fifo_empty && head.dc == dc_out) begin
            state_next = START;
          end else if (!fifo_empty) begin
            state_next = SETUP;
          end else begin
            state_next = HOLD;
            hold_next  = HW'(CS_HOLD - 1);
          end
        end
      end
      HOLD: begin
        if (!fifo_empty)        state_next = SETUP;
        else if (hold_cnt == '0) state_next = IDLE;
        else                    hold_next  = hold_cnt - 1'b1;
      end
      default:   state_next = IDLE;
    endcase
  end

  // Byte and D/C latch the head only on the way into SETUP/START, never mid-shift.
  assign load = (state_next == SETUP) || (state_next == START);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      hold_cnt <= '0;
      sr_data  <= '0;
      dc_out   <= DC_CMD;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      if (load) begin
        sr_data <= head.data;
        dc_out  <= head.dc;
      end
    end
  end

  assign cs_n_out = (state == IDLE);
  assign busy     = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_byte_feeder.sv
// Directed bench for spi_byte_feeder: a per-cycle vector table for a single
// command, then hand-written bursts, D/C switch, overflow, reset and late join.
module tb_spi_byte_feeder;
  import spi_byte_feeder_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CS_HOLD = 2;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_dc;
  logic       full;
  logic       sr_ready;
  logic       sr_start;
  logic [7:0] sr_data;
  logic       dc_out;
  logic       cs_n_out;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       prev_start = 1'b0;
  logic [8:0] got[$];

  spi_byte_feeder #(.DEPTH(DEPTH), .CS_HOLD(CS_HOLD)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_dc    (wr_dc),
    .full     (full),
    .sr_ready (sr_ready),
    .sr_start (sr_start),
    .sr_data  (sr_data),
    .dc_out   (dc_out),
    .cs_n_out (cs_n_out),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       dc;
    logic       rdy;
    logic       start;
    logic [7:0] data;
    logic       dco;
    logic       cs_n;
    logic       bsy;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, settle, then sample.
  task automatic cyc(input logic we, input logic [7:0] d, input logic dc, input logic rdy);
    @(negedge clk_in);
    wr_en    = we;
    wr_data  = d;
    wr_dc    = dc;
    sr_ready = rdy;
    #1;
    if (sr_start) check("start_protocol", {prev_start, sr_ready}, 2'b01);
    prev_start = sr_start;
  endtask

  // Shift-register model: ready drops for two cycles after each load strobe.
  task automatic run_sr(input int bound, input int bcnt0);
    int bcnt = bcnt0;
    bit done = 1'b0;
    got.delete();
    for (int i = 0; i < bound && !done; i++) begin
      cyc(1'b0, 8'h00, 1'b0, bcnt == 0);
      if (sr_start) begin
        got.push_back({dc_out, sr_data});
        bcnt = 2;
      end else if (bcnt > 0) begin
        bcnt--;
      end
      if (!busy && bcnt == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", busy, 0);
    check("drain_cs_released", cs_n_out, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".sr_start"}, sr_start, 0);
    check({tag, ".sr_data"},  sr_data,  0);
    check({tag, ".dc_out"},   dc_out,   0);
    check({tag, ".cs_n"},     cs_n_out, 1);
    check({tag, ".full"},     full,     0);
    check({tag, ".busy"},     busy,     0);
  endtask

  initial begin
    logic [7:0] ovf_exp [4];

    //            we   d      dc rdy  start data   dco cs_n busy
    tbl[0] = '{1'b1, 8'hAE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAE, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hAE, 1'b0, 1'b1, 1'b0};
    ovf_exp = '{8'h01, 8'h02, 8'h03, 8'h04};

    rst_in   = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    wr_dc    = DC_CMD;
    sr_ready = 1'b1;
    #2;
    check_reset_values("por");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Single command 0xAE: start three cycles after the write, CS released CS_HOLD+1 after ready.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].we, tbl[i].d, tbl[i].dc, tbl[i].rdy);
      check($sformatf("vec%0d.sr_start", i), sr_start, tbl[i].start);
      check($sformatf("vec%0d.sr_data", i),  sr_data,  tbl[i].data);
      check($sformatf("vec%0d.dc_out", i),   dc_out,   tbl[i].dco);
      check($sformatf("vec%0d.cs_n", i),     cs_n_out, tbl[i].cs_n);
      check($sformatf("vec%0d.busy", i),     busy,     tbl[i].bsy);
      check($sformatf("vec%0d.full", i),     full,     0);
    end

    // Same-D/C burst: second start the cycle after ready returns, CS low throughout.
    cyc(1'b1, 8'h81, DC_CMD, 1'b1);
    cyc(1'b1, 8'h7F, DC_CMD, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("burst.setup_cs", cs_n_out, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("burst.start1", sr_start, 1);
    check("burst.data1", sr_data, 8'h81);
    cyc(1'b0, 8'h00, DC_CMD, 1'b0);
    check("burst.cs_wb", cs_n_out, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b0);
    check("burst.cs_wd", cs_n_out, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("burst.no_early_start", sr_start, 0);
    check("burst.cs_ready", cs_n_out, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("burst.start2", sr_start, 1);
    check("burst.data2", sr_data, 8'h7F);
    check("burst.cs_start2", cs_n_out, 0);
    run_sr(40, 2);
    check("burst.extra_bytes", 16'(got.size()), 0);

    // D/C switch: dc_out flips only in the SETUP after byte 1, CS stays low.
    cyc(1'b1, 8'hB0, DC_CMD, 1'b1);
    cyc(1'b1, 8'hFF, DC_DATA, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("dcsw.setup1_dc", dc_out, DC_CMD);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("dcsw.start1", sr_start, 1);
    check("dcsw.data1", sr_data, 8'hB0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("dcsw.wd_dc", dc_out, DC_CMD);
    check("dcsw.wd_start", sr_start, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("dcsw.setup2_dc", dc_out, DC_DATA);
    check("dcsw.setup2_data", sr_data, 8'hFF);
    check("dcsw.setup2_cs", cs_n_out, 0);
    check("dcsw.setup2_start", sr_start, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("dcsw.start2", sr_start, 1);
    check("dcsw.start2_dc", dc_out, DC_DATA);
    run_sr(40, 2);
    check("dcsw.extra_bytes", 16'(got.size()), 0);

    // Overflow: ready held low, six writes, only the first four survive.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(i + 1), DC_CMD, 1'b0);
      check($sformatf("ovf.full%0d", i), full, (i >= 4) ? 1 : 0);
      check($sformatf("ovf.no_start%0d", i), sr_start, 0);
    end
    run_sr(100, 0);
    check("ovf.count", 16'(got.size()), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("ovf.byte%0d", i), got[i], {DC_CMD, ovf_exp[i]});

    // Reset while waiting for the shift register to finish.
    cyc(1'b1, 8'h55, DC_DATA, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("rst.start", sr_start, 1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b0);
    check("rst.pre_data", sr_data, 8'h55);
    check("rst.pre_dc", dc_out, DC_DATA);
    #1 rst_in = 1'b1;
    #1;
    check_reset_values("rst");
    @(negedge clk_in);
    rst_in     = 1'b0;
    prev_start = 1'b0;
    cyc(1'b1, 8'h22, DC_CMD, 1'b1);
    run_sr(40, 0);
    check("rst.after_count", 16'(got.size()), 1);
    if (got.size() > 0) check("rst.after_byte", got[0], {DC_CMD, 8'h22});

    // Late join: a write during HOLD goes back to SETUP without releasing CS.
    cyc(1'b1, 8'h11, DC_DATA, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("late.start1", sr_start, 1);
    cyc(1'b0, 8'h00, DC_CMD, 1'b0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    cyc(1'b1, 8'h33, DC_DATA, 1'b1);
    check("late.hold_cs", cs_n_out, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("late.hold2_cs", cs_n_out, 0);
    check("late.hold2_start", sr_start, 0);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("late.setup_cs", cs_n_out, 0);
    check("late.setup_data", sr_data, 8'h33);
    check("late.setup_dc", dc_out, DC_DATA);
    cyc(1'b0, 8'h00, DC_CMD, 1'b1);
    check("late.start2", sr_start, 1);
    check("late.start2_data", sr_data, 8'h33);
    run_sr(40, 2);
    check("late.extra_bytes", 16'(got.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_byte_feeder.md
SPI_BYTE_FEEDER -- requirements
Module: spi_byte_feeder

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-002 Parameter CS_HOLD, default 2: cycles chip select stays asserted after the last byte completes; at least 1.
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 wr_en  input  1  push {wr_dc, wr_data} into the FIFO when full is low.
REQ-006 wr_data  input  8  byte to transmit.
REQ-007 wr_dc  input  1  SSD1306 D/C flag: 0 = command, 1 = data.
REQ-008 full  output  1  FIFO holds DEPTH entries.
REQ-009 sr_ready  input  1  ready from the downstream 8-bit shift register.
REQ-010 sr_start  output  1  one-cycle load strobe to the shift register.
REQ-011 sr_data  output  8  byte presented to the shift register.
REQ-012 dc_out  output  1  D/C pin to the display.
REQ-013 cs_n_out  output  1  active-low chip select to the display.
REQ-014 busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-015 FIFO: a write with full high is dropped with no state change; a write to an empty FIFO is visible to the FSM on the next cycle.
REQ-016 FIFO: a simultaneous push and pop when not full both take effect, and the occupancy is unchanged.
REQ-017 Pointers: log2(DEPTH)+1 bits each, wrapping modulo 2*DEPTH; full and empty are derived from pointer comparison.
REQ-018 FSM states: IDLE, SETUP, START, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-019 IDLE, FIFO non-empty -> SETUP.
REQ-020 SETUP (1 cycle): cs_n_out=0, dc_out=head dc; then -> START.
REQ-021 START: sr_start=1 only while sr_ready=1.
REQ-022 START: the FIFO pops in the same cycle sr_start=1; then -> WAIT_BUSY.
REQ-023 START: sr_data and dc_out hold the head entry.
REQ-024 START: if sr_ready=0, stay in START with sr_start=0.
REQ-025 WAIT_BUSY: wait for sr_ready=0, then -> WAIT_DONE.
REQ-026 WAIT_DONE: wait for sr_ready=1, then take the first matching branch:
  (a) FIFO non-empty and head dc == dc_out -> START, with no gap cycle.
  (b) FIFO non-empty and head dc differs -> SETUP, with cs_n_out held low.
  (c) FIFO empty -> HOLD, with the hold counter loaded to CS_HOLD-1.
REQ-027 HOLD: a non-empty FIFO -> SETUP with CS still asserted.
REQ-028 HOLD: otherwise the counter decrements; at 0 -> IDLE, and cs_n_out=1 from the next cycle.
REQ-029 sr_data and dc_out change only in SETUP or START, never while the shift register is busy.
REQ-030 sr_start is never high in two consecutive cycles.
REQ-031 sr_start is never high while sr_ready=0.
REQ-032 cs_n_out is low in every non-IDLE state.
REQ-033 Byte latency: from a write into an empty idle block to sr_start takes 3 cycles (write edge, IDLE->SETUP, SETUP->START).

Reset
REQ-034 When rst_in asserts, at any time including mid-byte, the block goes immediately to: FSM IDLE; FIFO pointers 0; hold counter 0; sr_start=0; sr_data=0; dc_out=0; cs_n_out=1; full=0; busy=0.
REQ-035 After rst_in deasserts, the first state change occurs on the next rising clk_in.
REQ-036 The block does not wait for the shift register to finish after a reset.

Structure
REQ-037 The shared package holds the FSM state enum and constants DC_CMD=0 and DC_DATA=1.
REQ-038 The FIFO is one sub-module, spi_byte_fifo, with a 9-bit entry {dc, data} and DEPTH parameter.
REQ-039 The FSM and hold counter live in spi_byte_feeder.

Verification
REQ-040 Single command: write 0xAE with dc=0; then sr_start=1 with sr_data=0xAE, dc_out=0, cs_n_out=0 three cycles later.
REQ-041 Single command, release: in the same run, cs_n_out=1 CS_HOLD+1 cycles after sr_ready returns high.
REQ-042 Burst of same dc: write 0x81,0x7F with dc=0 back-to-back; then the second sr_start occurs the cycle after sr_ready returns high, with no SETUP and CS low throughout.
REQ-043 D/C switch: write 0xB0 with dc=0, then 0xFF with dc=1; dc_out goes 0->1 only in the SETUP cycle after byte 1 completes, and cs_n_out stays low.
REQ-044 Overflow: hold sr_ready=0 and write 6 bytes with DEPTH=4; full=1 after 4 writes, the extra writes are dropped, and exactly 4 bytes are transmitted in order.
REQ-045 Reset mid-byte: assert rst_in in WAIT_DONE; outputs immediately take the REQ-034 values, and a following write of 0x22 transmits normally.
REQ-046 Late join: a write during HOLD goes -> SETUP without cs_n_out rising.
